// File: rtl/dm_sba_arbiter.sv
// Round-robin arbiter sharing one system-bus master port among NumReq requesters.
// Optional response watchdog: define SBA_ARB_TIMEOUT_EN.
module dm_sba_arbiter #(
    parameter int BusWidth      = 32,
    parameter int NumReq        = 2,
    parameter int TimeoutCycles = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumReq-1:0]            slv_req_i,
    input  logic [NumReq*BusWidth-1:0]   slv_add_i,
    input  logic [NumReq-1:0]            slv_we_i,
    input  logic [NumReq*BusWidth-1:0]   slv_wdata_i,
    input  logic [NumReq*BusWidth/8-1:0] slv_be_i,
    output logic [NumReq-1:0]            slv_gnt_o,
    output logic [NumReq-1:0]            slv_r_valid_o,
    output logic [BusWidth-1:0]          slv_r_rdata_o,
    output logic                         slv_err_o,
    output logic                         master_req_o,
    output logic [BusWidth-1:0]          master_add_o,
    output logic                         master_we_o,
    output logic [BusWidth-1:0]          master_wdata_o,
    output logic [BusWidth/8-1:0]        master_be_o,
    input  logic                         master_gnt_i,
    input  logic                         master_r_valid_i,
    input  logic [BusWidth-1:0]          master_r_rdata_i,
    output logic                         busy_o,
    output logic [$clog2(NumReq)-1:0]    owner_o
);

    localparam int IdxW = $clog2(NumReq);
    localparam int BeW  = BusWidth / 8;

    typedef enum logic [1:0] {
        Idle,
        Req,
        Wait
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [IdxW-1:0]   owner_nxt;

`ifdef SBA_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0]   cnt_q, cnt_d;
`endif

    // Pointer value one past the current owner, wrapping at NumReq.
    always_comb begin
        owner_nxt = owner_q + 1'b1;
        if (int'(owner_q) == NumReq - 1) begin
            owner_nxt = '0;
        end
    end

    // Next-state, arbitration and output decode.
    always_comb begin
        int idx;
        logic found;
        logic [IdxW-1:0] pick;
        state_d        = state_q;
        owner_d        = owner_q;
        rr_d           = rr_q;
        slv_gnt_o      = '0;
        slv_r_valid_o  = '0;
        slv_r_rdata_o  = '0;
        slv_err_o      = 1'b0;
        master_req_o   = 1'b0;
        master_add_o   = '0;
        master_we_o    = 1'b0;
        master_wdata_o = '0;
        master_be_o    = '0;
        idx            = 0;
        found          = 1'b0;
        pick           = rr_q;
`ifdef SBA_ARB_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif
        unique case (state_q)
            Idle: begin
                for (int i = 0; i < NumReq; i++) begin
                    idx = int'(rr_q) + i;
                    if (idx >= NumReq) begin
                        idx = idx - NumReq;
                    end
                    if (!found && slv_req_i[idx]) begin
                        found = 1'b1;
                        pick  = IdxW'(idx);
                    end
                end
                if (found) begin
                    owner_d = pick;
                    state_d = Req;
                end
            end
            Req: begin
                master_add_o   = slv_add_i[int'(owner_q)*BusWidth +: BusWidth];
                master_we_o    = slv_we_i[owner_q];
                master_wdata_o = slv_wdata_i[int'(owner_q)*BusWidth +: BusWidth];
                master_be_o    = slv_be_i[int'(owner_q)*BeW +: BeW];
                if (!slv_req_i[owner_q]) begin
                    state_d = Idle;
                end else begin
                    master_req_o = 1'b1;
                    if (master_gnt_i) begin
                        slv_gnt_o[owner_q] = 1'b1;
                        state_d = Wait;
`ifdef SBA_ARB_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end
                end
            end
            Wait: begin
                if (master_r_valid_i) begin
                    slv_r_valid_o[owner_q] = 1'b1;
                    slv_r_rdata_o = master_r_rdata_i;
                    rr_d    = owner_nxt;
                    state_d = Idle;
                end
`ifdef SBA_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    slv_r_valid_o[owner_q] = 1'b1;
                    slv_err_o = 1'b1;
                    rr_d      = owner_nxt;
                    state_d   = Idle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = Idle;
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

`ifdef SBA_ARB_TIMEOUT_EN
    // Response watchdog counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign busy_o  = (state_q != Idle);
    assign owner_o = owner_q;

endmodule

// File: tb/tb_dm_sba_arbiter.sv
// Scoreboard bench for dm_sba_arbiter: grants and responses checked against
// queues of expected values pushed when the bus stimulus is driven.
module tb_dm_sba_arbiter;

    localparam int BW = 32;
    localparam int NR = 2;

    typedef struct {
        int          own;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [1:0]    slv_req_i;
    logic [63:0]   slv_add_i;
    logic [1:0]    slv_we_i;
    logic [63:0]   slv_wdata_i;
    logic [7:0]    slv_be_i;
    logic [1:0]    slv_gnt_o;
    logic [1:0]    slv_r_valid_o;
    logic [31:0]   slv_r_rdata_o;
    logic          slv_err_o;
    logic          master_req_o;
    logic [31:0]   master_add_o;
    logic          master_we_o;
    logic [31:0]   master_wdata_o;
    logic [3:0]    master_be_o;
    logic          master_gnt_i;
    logic          master_r_valid_i;
    logic [31:0]   master_r_rdata_i;
    logic          busy_o;
    logic [0:0]    owner_o;

    logic [31:0]   add_a[NR];
    logic [31:0]   wd_a[NR];
    logic [3:0]    be_a[NR];

    int            n_chk = 0;
    int            n_fail = 0;
    int            lat;
    int            gq[$];
    rsp_t          rq[$];

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            slv_add_i[i*BW +: BW]   = add_a[i];
            slv_wdata_i[i*BW +: BW] = wd_a[i];
            slv_be_i[i*4 +: 4]      = be_a[i];
        end
    end

    dm_sba_arbiter #(
        .BusWidth(BW),
        .NumReq(NR),
        .TimeoutCycles(4)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .slv_req_i(slv_req_i),
        .slv_add_i(slv_add_i),
        .slv_we_i(slv_we_i),
        .slv_wdata_i(slv_wdata_i),
        .slv_be_i(slv_be_i),
        .slv_gnt_o(slv_gnt_o),
        .slv_r_valid_o(slv_r_valid_o),
        .slv_r_rdata_o(slv_r_rdata_o),
        .slv_err_o(slv_err_o),
        .master_req_o(master_req_o),
        .master_add_o(master_add_o),
        .master_we_o(master_we_o),
        .master_wdata_o(master_wdata_o),
        .master_be_o(master_be_o),
        .master_gnt_i(master_gnt_i),
        .master_r_valid_i(master_r_valid_i),
        .master_r_rdata_i(master_r_rdata_i),
        .busy_o(busy_o),
        .owner_o(owner_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops expected grants/responses when the DUT produces them.
    always begin
        @(negedge clk_i);
        #2;
        if (rst_ni) begin
            if (|slv_gnt_o) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexp", 64'(slv_gnt_o), 0);
                end else begin
                    chk("gnt", 64'(slv_gnt_o), 64'(1) << gq.pop_front());
                end
            end
            if (|slv_r_valid_o) begin
                if (rq.size() == 0) begin
                    chk("rv_unexp", 64'(slv_r_valid_o), 0);
                end else begin
                    rsp_t r;
                    r = rq.pop_front();
                    chk("rv", 64'(slv_r_valid_o), 64'(1) << r.own);
                    chk("rdata", 64'(slv_r_rdata_o), 64'(r.data));
                    chk("err", 64'(slv_err_o), 64'(r.err));
                end
            end else if (slv_r_rdata_o != 0 || slv_err_o) begin
                chk("rdata_idle", {slv_err_o, slv_r_rdata_o}, 0);
            end
        end
    end

    // One bus transaction: wait for master_req_o, grant after gdly cycles,
    // respond the cycle after the grant.
    task automatic bus_txn(input int own, input int gdly,
                           input logic [31:0] rd, input logic [1:0] drop);
        int k;
        k = 0;
        #1;
        while (!master_req_o && k < 20) begin
            @(negedge clk_i);
            #1;
            k++;
        end
        lat = k;
        chk("req_seen", 64'(master_req_o), 1);
        chk("owner", 64'(owner_o), 64'(own));
        chk("m_add", 64'(master_add_o), 64'(add_a[own]));
        chk("m_we", 64'(master_we_o), 64'(slv_we_i[own]));
        chk("m_wdata", 64'(master_wdata_o), 64'(wd_a[own]));
        chk("m_be", 64'(master_be_o), 64'(be_a[own]));
        repeat (gdly) begin
            @(negedge clk_i);
            #1;
        end
        gq.push_back(own);
        master_gnt_i = 1'b1;
        @(negedge clk_i);
        #1;
        master_gnt_i     = 1'b0;
        master_r_valid_i = 1'b1;
        master_r_rdata_i = rd;
        slv_req_i        = slv_req_i & ~drop;
        rq.push_back('{own, rd, 1'b0});
        #1;
        chk("m_wait", {master_req_o, master_add_o, master_wdata_o}, 0);
        @(negedge clk_i);
        #1;
        master_r_valid_i = 1'b0;
        master_r_rdata_i = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni           = 1'b0;
        slv_req_i        = '0;
        slv_we_i         = '0;
        master_gnt_i     = 1'b0;
        master_r_valid_i = 1'b0;
        master_r_rdata_i = '0;
        add_a[0] = 32'h1000;
        wd_a[0]  = 32'h1111_1111;
        be_a[0]  = 4'h3;
        add_a[1] = 32'h2000;
        wd_a[1]  = 32'hA5A5_A5A5;
        be_a[1]  = 4'hF;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_ctl", {master_req_o, master_we_o, busy_o, slv_gnt_o,
                        slv_r_valid_o, slv_err_o}, 0);
        chk("rst_data", {master_add_o, master_wdata_o}, 0);
        chk("rst_owner", 64'(owner_o), 0);
        rst_ni = 1'b1;

        // Contention from pointer 0: grants 0,1,0,1.
        @(negedge clk_i);
        slv_req_i = 2'b11;
        bus_txn(0, 0, 32'h0000_0A00, 2'b00);
        bus_txn(1, 1, 32'h0000_0A01, 2'b00);
        bus_txn(0, 0, 32'h0000_0A02, 2'b00);
        bus_txn(1, 0, 32'h0000_0A03, 2'b11);

        // Single read from requester 0.
        @(negedge clk_i);
        slv_req_i = 2'b01;
        bus_txn(0, 2, 32'hDEAD_BEEF, 2'b01);
        chk("latency", 64'(lat), 1);

        // Write from requester 1.
        @(negedge clk_i);
        slv_we_i  = 2'b10;
        slv_req_i = 2'b10;
        bus_txn(1, 1, 32'h1234_5678, 2'b10);
        slv_we_i  = 2'b00;

        // Abort: requester 0 drops before grant.
        @(negedge clk_i);
        slv_req_i = 2'b01;
        @(negedge clk_i);
        #1;
        chk("abort_req", 64'(master_req_o), 1);
        slv_req_i = 2'b00;
        #1;
        chk("abort_fall", 64'(master_req_o), 0);
        @(negedge clk_i);
        #1;
        chk("abort_busy", 64'(busy_o), 0);

        // Response never arrives.
        @(negedge clk_i);
        slv_req_i = 2'b01;
        @(negedge clk_i);
        #1;
        chk("to_req", 64'(master_req_o), 1);
        gq.push_back(0);
        master_gnt_i = 1'b1;
        @(negedge clk_i);
        #1;
        master_gnt_i = 1'b0;
        slv_req_i    = 2'b00;
`ifdef SBA_ARB_TIMEOUT_EN
        rq.push_back('{0, 32'h0, 1'b1});
        repeat (4) @(negedge clk_i);
        #1;
        master_r_valid_i = 1'b1;
        master_r_rdata_i = 32'h0BAD_0BAD;
        #1;
        chk("to_late_rv", 64'(slv_r_valid_o), 0);
        chk("to_busy", 64'(busy_o), 0);
        @(negedge clk_i);
        #1;
        master_r_valid_i = 1'b0;
        master_r_rdata_i = '0;
`else
        repeat (6) @(negedge clk_i);
        #1;
        chk("to_busy", 64'(busy_o), 1);
        rq.push_back('{0, 32'hCAFE_F00D, 1'b0});
        master_r_valid_i = 1'b1;
        master_r_rdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        #1;
        master_r_valid_i = 1'b0;
        master_r_rdata_i = '0;
        chk("to_idle", 64'(busy_o), 0);
`endif

        // Reset while waiting for a response.
        @(negedge clk_i);
        slv_req_i = 2'b10;
        @(negedge clk_i);
        #1;
        chk("rw_owner", 64'(owner_o), 1);
        gq.push_back(1);
        master_gnt_i = 1'b1;
        @(negedge clk_i);
        #1;
        master_gnt_i = 1'b0;
        chk("rw_busy", 64'(busy_o), 1);
        rst_ni           = 1'b0;
        slv_req_i        = 2'b00;
        master_r_valid_i = 1'b1;
        master_r_rdata_i = 32'h5555_AAAA;
        #1;
        chk("rw_ctl", {master_req_o, busy_o, slv_gnt_o, slv_r_valid_o,
                       slv_err_o}, 0);
        chk("rw_data", {slv_r_rdata_o, master_add_o}, 0);
        chk("rw_owner0", 64'(owner_o), 0);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        master_r_valid_i = 1'b0;
        master_r_rdata_i = '0;
        chk("rw_drop", 64'(busy_o), 0);
        slv_req_i = 2'b11;
        bus_txn(0, 0, 32'h0000_0B00, 2'b00);
        bus_txn(1, 0, 32'h0000_0B01, 2'b11);

        repeat (3) @(negedge clk_i);
        chk("gq_empty", 64'(gq.size()), 0);
        chk("rq_empty", 64'(rq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
